// File: rtl/scroll_frame_gen.sv
// Scrolling-text frame generator: renders one 8x8 bitmap per scroll step from a
// small message RAM and a built-in font, and hands it downstream over valid/ready.
module scroll_frame_gen #(
  parameter int MSG_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        msg_we,
  input  logic [3:0]  msg_waddr,
  input  logic [3:0]  msg_wdata,
  input  logic [4:0]  msg_len,
  input  logic        run,
  input  logic        frame_ready,
  output logic        frame_valid,
  output logic [63:0] frame_data,
  output logic        frame_last
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    BUILD,
    PRESENT,
    ADVANCE
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  shift_q, shift_d;
  logic [3:0]  idx_q, idx_d;
  logic [4:0]  len_q, len_d;
  logic [3:0]  code_a_q, code_a_d;
  logic [3:0]  code_b_q, code_b_d;
  logic [2:0]  row_q, row_d;
  logic        frame_valid_q, frame_valid_d;
  logic [63:0] frame_data_q, frame_data_d;
  logic        frame_last_q, frame_last_d;

  logic [3:0]  ram_q [MSG_DEPTH];

  logic [4:0]  len_clamp;
  logic [3:0]  idx_fetch;
  logic [3:0]  idx_fetch_next;
  logic [3:0]  idx_adv_next;
  logic [15:0] pair_shifted;
  logic [7:0]  row_byte;
  logic [5:0]  row_base;

  // Rows 1..6 of each glyph packed MSB-first; rows 0 and 7 are always blank.
  function automatic logic [7:0] font_row(input logic [3:0] code, input logic [2:0] row);
    logic [47:0] glyph;
    case (code)
      4'd1:    glyph = 48'h606c766666e6;
      4'd2:    glyph = 48'h0078ccfcc078;
      4'd3:    glyph = 48'h303030303078;
      4'd4:    glyph = 48'h0078cccccc78;
      default: glyph = 48'h0;
    endcase
    if (row == 3'd0 || row == 3'd7) begin
      font_row = 8'h00;
    end else begin
      font_row = glyph[{3'd6 - row, 3'b000} +: 8];
    end
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MSG_DEPTH; i++) begin
        ram_q[i] <= '0;
      end
    end else if (msg_we) begin
      ram_q[msg_waddr] <= msg_wdata;
    end
  end

  always_comb begin
    len_clamp = msg_len;
    if (msg_len == 5'd0) begin
      len_clamp = 5'd1;
    end else if (msg_len > 5'(MSG_DEPTH)) begin
      len_clamp = 5'(MSG_DEPTH);
    end
    idx_fetch      = ({1'b0, idx_q} >= len_clamp) ? 4'd0 : idx_q;
    idx_fetch_next = ({1'b0, idx_fetch} + 5'd1 == len_clamp) ? 4'd0 : idx_fetch + 4'd1;
    idx_adv_next   = ({1'b0, idx_q} + 5'd1 == len_q) ? 4'd0 : idx_q + 4'd1;
    // The upper byte of {A,B}<<shift is exactly (A<<shift)|(B>>(8-shift)).
    pair_shifted   = {font_row(code_a_q, row_q), font_row(code_b_q, row_q)} << shift_q;
    row_byte       = pair_shifted[15:8];
    row_base       = {3'd7 - row_q, 3'b000};
  end

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    idx_d         = idx_q;
    len_d         = len_q;
    code_a_d      = code_a_q;
    code_b_d      = code_b_q;
    row_d         = row_q;
    frame_valid_d = frame_valid_q;
    frame_data_d  = frame_data_q;
    frame_last_d  = frame_last_q;
    case (state_q)
      IDLE: begin
        if (run) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        len_d    = len_clamp;
        idx_d    = idx_fetch;
        code_a_d = ram_q[idx_fetch];
        code_b_d = ram_q[idx_fetch_next];
        row_d    = 3'd1;
        state_d  = BUILD;
      end
      BUILD: begin
        frame_data_d[row_base +: 8] = row_byte;
        if (row_q == 3'd6) begin
          frame_valid_d = 1'b1;
          frame_last_d  = (shift_q == 3'd7) && ({1'b0, idx_q} == len_q - 5'd1);
          state_d       = PRESENT;
        end else begin
          row_d = row_q + 3'd1;
        end
      end
      PRESENT: begin
        // The frame stays on offer even if run drops; only a handshake retires it.
        if (frame_ready) begin
          frame_valid_d = 1'b0;
          state_d       = ADVANCE;
        end
      end
      ADVANCE: begin
        if (shift_q == 3'd7) begin
          shift_d = 3'd0;
          idx_d   = idx_adv_next;
        end else begin
          shift_d = shift_q + 3'd1;
        end
        state_d = run ? FETCH : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      idx_q         <= '0;
      len_q         <= 5'd1;
      code_a_q      <= '0;
      code_b_q      <= '0;
      row_q         <= '0;
      frame_valid_q <= 1'b0;
      frame_data_q  <= '0;
      frame_last_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      idx_q         <= idx_d;
      len_q         <= len_d;
      code_a_q      <= code_a_d;
      code_b_q      <= code_b_d;
      row_q         <= row_d;
      frame_valid_q <= frame_valid_d;
      frame_data_q  <= frame_data_d;
      frame_last_q  <= frame_last_d;
    end
  end

  assign frame_valid = frame_valid_q;
  assign frame_data  = frame_data_q;
  assign frame_last  = frame_last_q;

endmodule
